// File: rtl/review2015_tx.sv
// rtl/review2015_tx.sv - serial delay-command transmitter with done handshake and timeout
// Sends preamble 1,1,0,1 plus a 4-bit delay MSB first, then waits for done or TIMEOUT.
module review2015_tx #(
  parameter int TIMEOUT = 20000
) (
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       start_i,
  input  logic [3:0] delay_i,
  input  logic       done_i,
  output logic       data_o,
  output logic       ack_o,
  output logic       busy_o,
  output logic       timeout_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_P0, S_P1, S_P2, S_P3,
    S_D3, S_D2, S_D1, S_D0,
    S_WAIT_DONE, S_ACK, S_TOUT
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [3:0]  delay_q, delay_d;
  logic [15:0] cnt_q, cnt_d;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= S_IDLE;
      delay_q <= 4'd0;
      cnt_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      delay_q <= delay_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    delay_d = delay_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d = S_P0;
          delay_d = delay_i;
        end
      end
      S_P0: state_d = S_P1;
      S_P1: state_d = S_P2;
      S_P2: state_d = S_P3;
      S_P3: state_d = S_D3;
      S_D3: state_d = S_D2;
      S_D2: state_d = S_D1;
      S_D1: state_d = S_D0;
      S_D0: begin
        state_d = S_WAIT_DONE;
        cnt_d   = 16'd0;
      end
      S_WAIT_DONE: begin
        // done takes priority over the terminal count on the same edge
        if (done_i) begin
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_q == CNT_LAST) state_d = S_TOUT;
        end
      end
      S_ACK:   state_d = S_IDLE;
      S_TOUT:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    data_o = 1'b0;
    case (state_q)
      S_P0, S_P1, S_P3: data_o = 1'b1;
      S_D3:    data_o = delay_q[3];
      S_D2:    data_o = delay_q[2];
      S_D1:    data_o = delay_q[1];
      S_D0:    data_o = delay_q[0];
      default: data_o = 1'b0;
    endcase
  end

  assign busy_o    = (state_q != S_IDLE);
  assign ack_o     = (state_q == S_ACK);
  assign timeout_o = (state_q == S_TOUT);

endmodule

// File: tb/tb_review2015_tx.sv
// tb/tb_review2015_tx.sv - scoreboard bench for review2015_tx
module tb_review2015_tx;

  typedef struct {
    int    cyc;
    logic  d;
    logic  b;
    logic  a;
    logic  t;
    string nm;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       start = 1'b0;
  logic       done = 1'b0;
  logic [3:0] delay = 4'd0;
  logic       data, ack, busy, tout;

  int   cyc = 0;
  int   n_chk = 0;
  int   n_err = 0;
  exp_t q[$];
  exp_t m;

  always #5 clk = ~clk;

  review2015_tx #(.TIMEOUT(8)) dut (
    .clk_i     (clk),
    .reset_ni  (reset_n),
    .start_i   (start),
    .delay_i   (delay),
    .done_i    (done),
    .data_o    (data),
    .ack_o     (ack),
    .busy_o    (busy),
    .timeout_o (tout)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic act, input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: pops the expectation tagged for the current cycle.
  always @(negedge clk) begin
    while (q.size() > 0 && q[0].cyc < cyc) begin
      m = q.pop_front();
      n_chk++;
      n_err++;
      $display("FAIL %s_unchecked: expectation for cycle %0d never sampled (now %0d)", m.nm, m.cyc, cyc);
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      m = q.pop_front();
      chk({m.nm, "_data"},    data, m.d);
      chk({m.nm, "_busy"},    busy, m.b);
      chk({m.nm, "_ack"},     ack,  m.a);
      chk({m.nm, "_timeout"}, tout, m.t);
    end
  end

  // Drive inputs for the next edge and queue the outputs expected after it.
  task automatic cycle(input logic st, input logic [3:0] dl, input logic dn,
                       input logic ed, input logic eb, input logic ea, input logic et,
                       input string nm);
    exp_t e;
    start = st;
    delay = dl;
    done  = dn;
    e.cyc = cyc + 1;
    e.d = ed; e.b = eb; e.a = ea; e.t = et; e.nm = nm;
    q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  task automatic frame(input logic [3:0] dl, input logic [7:0] bits, input logic st_hold,
                       input logic [3:0] dl_mid, input logic dn, input int ncalls,
                       input string nm);
    cycle(1'b1, dl, 1'b0, bits[7], 1'b1, 1'b0, 1'b0, {nm, "_p0"});
    for (int k = 2; k <= ncalls; k++) begin
      if (k <= 8)
        cycle(st_hold, dl_mid, dn, bits[8-k], 1'b1, 1'b0, 1'b0, $sformatf("%s_bit%0d", nm, k));
      else
        cycle(st_hold, dl_mid, dn, 1'b0, 1'b1, 1'b0, 1'b0, {nm, "_wait1"});
    end
  endtask

  // n calls spent in WAIT_DONE; the last one applies end_done.
  task automatic run_wait(input int n, input logic end_done, input logic st, input string nm);
    for (int k = 1; k < n; k++)
      cycle(st, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, $sformatf("%s_w%0d", nm, k));
    cycle(st, 4'h0, end_done, 1'b0, 1'b1, end_done, !end_done, {nm, "_end"});
  endtask

  initial begin
    #1 reset_n = 1'b0;
    #2;
    chk("reset_data", data, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_ack", ack, 1'b0);
    chk("reset_timeout", tout, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    // nominal 1010 frame, start on the first edge after release, done on 5th wait cycle
    frame(4'b1010, 8'b1101_1010, 1'b0, 4'b0000, 1'b0, 9, "nom");
    run_wait(5, 1'b1, 1'b0, "hs");
    cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "idle_a");
    cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "idle_a2");

    // timeout with done pulsed high during the frame (ignored there)
    frame(4'b0110, 8'b1101_0110, 1'b0, 4'b1111, 1'b1, 9, "tofr");
    run_wait(8, 1'b0, 1'b0, "to");
    cycle(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "idle_b");
    cycle(1'b0, 4'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "idle_b2");

    // done and terminal count on the same edge
    frame(4'b1111, 8'b1101_1111, 1'b0, 4'b0000, 1'b0, 9, "pri");
    run_wait(8, 1'b1, 1'b0, "pri");
    cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "idle_c");

    // start held high, delay changed mid-frame, back-to-back frames
    frame(4'b0001, 8'b1101_0001, 1'b1, 4'b1110, 1'b0, 9, "b2b1");
    run_wait(3, 1'b1, 1'b1, "b2b1");
    cycle(1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "b2b_gap");
    frame(4'b0100, 8'b1101_0100, 1'b0, 4'b0000, 1'b0, 9, "b2b2");
    run_wait(2, 1'b1, 1'b0, "b2b2");
    cycle(1'b0, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "idle_d");

    // reset asserted while D2 is on the line
    frame(4'b1001, 8'b1101_1001, 1'b0, 4'b0000, 1'b0, 6, "rst");
    @(negedge clk);
    #1;
    start = 1'b0;
    reset_n = 1'b0;
    #1;
    chk("midrst_data", data, 1'b0);
    chk("midrst_busy", busy, 1'b0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 0; k < 4; k++)
      cycle(1'b0, 4'hF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "post_rst");

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() != 0) begin
      n_chk++;
      n_err++;
      $display("FAIL drain: %0d expectations left, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/review2015_tx.md
REVIEW2015_TX -- requirements
Module: review2015_tx

Interface
REQ-001 Parameter: TIMEOUT, default 20000, maximum cycles spent in WAIT_DONE before the frame is abandoned (range 1..65535).
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  frame request; sampled only in IDLE.
REQ-005 delay  input  4  delay value to transmit; captured on the edge that accepts start.
REQ-006 done  input  1  far-end timer-expired indication; sampled only in WAIT_DONE.
REQ-007 data  output  1  serial command stream to the far-end receiver.
REQ-008 ack  output  1  one-cycle acknowledge of done.
REQ-009 busy  output  1  high in every state except IDLE.
REQ-010 timeout  output  1  one-cycle pulse when TIMEOUT expires without done.

Function
REQ-011 States SHALL be IDLE, P0, P1, P2, P3, D3, D2, D1, D0, WAIT_DONE, ACK and TOUT.
REQ-012 All outputs SHALL be Moore decodes of the state register and delay_q; there is no combinational path from any input to any output.
REQ-013 IDLE: start=1 -> P0 with delay_q<=delay; start=0 -> remain in IDLE.
REQ-014 P0->P1->P2->P3->D3->D2->D1->D0->WAIT_DONE SHALL advance unconditionally, one state per cycle.
REQ-015 data SHALL be 1 in P0, P1 and P3, 0 in P2, and delay_q[n] in Dn, giving the sequence 1,1,0,1 followed by delay MSB first.
REQ-016 data SHALL be 0 in IDLE, WAIT_DONE, ACK and TOUT.
REQ-017 Latency: start sampled at edge k -> first preamble bit on data during cycle k+1; last delay bit during cycle k+8.
REQ-018 WAIT_DONE: a 16-bit counter SHALL clear on entry and increment on each WAIT_DONE cycle in which done=0.
REQ-019 WAIT_DONE exits: done=1 -> ACK; done=0 with counter==TIMEOUT-1 -> TOUT; otherwise remain in WAIT_DONE.
REQ-020 If done=1 and the counter terminal condition occur on the same edge, done SHALL win and the next state is ACK.
REQ-021 ACK SHALL assert ack=1 for exactly one cycle, then go to IDLE.
REQ-022 TOUT SHALL assert timeout=1 for exactly one cycle, then go to IDLE.
REQ-023 start while busy=1 SHALL be ignored and not queued; delay_q SHALL be stable from P0 through D0.
REQ-024 done outside WAIT_DONE SHALL be ignored.
REQ-025 After ACK or TOUT, at least one IDLE cycle with data=0 SHALL precede the next P0, even if start is held high.

Reset
REQ-026 reset=0 SHALL immediately force state=IDLE, delay_q=0, counter=0, data=0, ack=0, busy=0, timeout=0, independent of clk.
REQ-027 Reset asserted mid-frame SHALL abort the frame; no partial bits are emitted after reset is released.
REQ-028 After reset is released, the first edge SHALL be treated as IDLE, so start=1 on that edge is accepted.

Verification
REQ-029 Nominal frame: delay=4'b1010, one-cycle start pulse -> data=1,1,0,1,1,0,1,0 on cycles k+1..k+8, then 0; busy=1 from k+1.
REQ-030 Done handshake: done=1 on the 5th WAIT_DONE cycle -> ack=1 for exactly one cycle on the next cycle, then busy=0; timeout stays 0.
REQ-031 Timeout: TIMEOUT=8, done held 0 -> timeout=1 for one cycle after 8 WAIT_DONE cycles, then IDLE; ack stays 0.
REQ-032 Priority: TIMEOUT=8, done=1 on the 8th WAIT_DONE cycle -> ack pulse, no timeout pulse.
REQ-033 Busy rejection and back-to-back: start held high with delay changed mid-frame -> transmitted bits use the captured delay; the next P0 follows exactly one IDLE cycle after ACK.
REQ-034 Reset mid-frame: reset=0 during D2 -> data=0 and busy=0 immediately; after release with start=0, data stays 0.
